arm_data_bus: RTL and testbench
===============================

# arm_data_bus

Data-side bus slave directly downstream of `arm_top`. It consumes the core's `MemWrite`/`DataAdr`/`WriteData` and returns `ReadData`. It decodes each access into one of three targets: word RAM, a register bank (LEDs, status, cycle counter) or an 8-bit transmit FIFO. The FIFO drains through a valid/ready handshake to a downstream byte sink such as a UART TX.

## Interface
Parameters:
- `RAM_WORDS`, 64, number of 32-bit data RAM words; power of two.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `MemWrite`  in  1  write strobe from the core.
- `DataAdr`  in  32  byte address from the core; bits [1:0] ignored.
- `WriteData`  in  32  store data from the core.
- `ReadData`  out  32  combinational load data to the core.
- `leds`  out  8  registered LED register.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts the head byte this cycle.
- `bus_err`  out  1  sticky flag; set by a write to an unmapped address.

## Operation
Address map (word-aligned):
- `0x0000_0000`..`RAM_WORDS*4-1` (RAM): word index is `DataAdr[log2(RAM_WORDS)+1:2]`. A write stores all 32 bits.
- `0x0000_1000` (LED): write loads `leds <= WriteData[7:0]`. Read returns `{24'b0, leds}`.
- `0x0000_1004` (TX): write pushes `WriteData[7:0]`. Read returns 0.
- `0x0000_1008` (STATUS), read-only fields:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow, sticky
  - bits[12:8] = count, zero-extended
  - A write with `WriteData[2]=1` clears overflow. Other write bits are ignored.
- `0x0000_100C` (CYCLES): read returns the free-running 32-bit cycle counter. Writes are ignored; they are not an error.
- Any other address: read returns 0. A write sets `bus_err`, which stays 1 until reset.

FIFO behaviour:
- Circular buffer with read/write pointers and a count of width `log2(FIFO_DEPTH)+1`.
- Push, when not full: the entry is stored at the write pointer and the pointer wraps modulo depth.
- Push when full and no pop in the same cycle: the byte is dropped, overflow is set, and FIFO state is unchanged.
- Pop: occurs when `tx_valid && tx_ready`. The read pointer advances and wraps.
- Simultaneous push and pop:
  - When full, both are accepted, the count stays at depth, and no overflow is raised.
  - When empty, only the push takes effect; the pop is impossible because `tx_valid=0`.
- `tx_data` equals the entry at the read pointer. It is undefined (don't-care) when empty.

Cycle counter:
- Increments every cycle not in reset and wraps `0xFFFF_FFFF -> 0`.

Reset values (reset also applies mid-operation):
- `leds=0`, FIFO empty (pointers 0, count 0), overflow 0, counter 0, `bus_err=0`, hence `tx_valid=0`.
- Queued bytes are discarded.
- RAM contents are not reset.

## Timing
- `ReadData` is combinational from `DataAdr` and current state; the core sees it in the same cycle.
- Write effects (RAM, LED, push, overflow clear, `bus_err`) become visible on the cycle after the write edge.
  - A read of an address in the same cycle it is written returns the old value.
- Pushed byte latency: `tx_valid` rises on the first cycle after the push edge. There is no fall-through.
- `tx_valid` falls on the cycle after the pop of the last entry.
- CYCLES reads 0 in the first cycle after `reset` deasserts and N in the N-th following cycle.
- `reset` asserted with `MemWrite=1` in the same cycle: reset wins, except that the RAM write still commits.

## Test plan
- RAM write/read: reset; store `7` to `0x64`, then load `0x64` -> `ReadData=7` on the next cycle. Load `0x60` in the same cycle as a store to it -> old value.
- LED register: write `0x1A5` to `0x1000` -> `leds=0xA5` next cycle. Assert reset -> `leds=0`.
- FIFO fill/overflow: `tx_ready=0`; push bytes `1..9` to `0x1004` -> STATUS full=1, count=8, overflow=1. Write STATUS `0x4` -> overflow=0. Raise `tx_ready` -> bytes `1..8` appear in order, then `tx_valid=0`, empty=1.
- Full push+pop: with FIFO full and `tx_ready=1`, push `0x55` -> count stays 8, overflow=0, `0x55` emerges eighth.
- Unmapped access and counter: write to `0x2000` -> `bus_err=1` until reset. Read `0x2000` -> 0. Read `0x100C` at the 5th cycle after reset release -> 5.
- Mid-operation reset: with 3 bytes queued, pulse reset for one cycle -> `tx_valid=0`, count 0. RAM word at `0x64` still reads 7.

Source files
------------

// File: rtl/arm_data_bus.sv
// Data-side bus slave for arm_top: word RAM, LED/status/cycle registers and
// a byte-wide TX FIFO that drains to a valid/ready sink.
module arm_data_bus #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  leds,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        bus_err
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;

   localparam logic [29:0] LED_WADR    = 30'h400;
   localparam logic [29:0] TX_WADR     = 30'h401;
   localparam logic [29:0] STATUS_WADR = 30'h402;
   localparam logic [29:0] CYCLES_WADR = 30'h403;

   logic [31:0]       ram_mem [RAM_WORDS];
   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [31:0]       cycles;

   logic [29:0]       wadr;
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_hit;
   logic              led_hit;
   logic              tx_hit;
   logic              status_hit;
   logic              cycles_hit;
   logic              unmapped;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              do_push;
   logic [4:0]        count5;
   logic              unused_adr_bits;

   assign unused_adr_bits = ^DataAdr[1:0];

   assign wadr       = DataAdr[31:2];
   assign ram_idx    = DataAdr[RAM_AW+1:2];
   assign ram_hit    = (DataAdr[31:RAM_AW+2] == '0);
   assign led_hit    = (wadr == LED_WADR);
   assign tx_hit     = (wadr == TX_WADR);
   assign status_hit = (wadr == STATUS_WADR);
   assign cycles_hit = (wadr == CYCLES_WADR);
   assign unmapped   = !(ram_hit || led_hit || tx_hit || status_hit || cycles_hit);

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign tx_valid = !empty;
   assign tx_data  = fifo_mem[rd_ptr];
   assign count5   = 5'(count);

   assign push    = MemWrite && tx_hit;
   assign pop     = tx_valid && tx_ready;
   // When full, a push is only accepted if the head leaves in the same cycle.
   assign do_push = push && (!full || pop);

   // RAM has no reset, so a store issued during reset still commits.
   always_ff @(posedge clk) begin
      if (MemWrite && ram_hit)
         ram_mem[ram_idx] <= WriteData;
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push)
         fifo_mem[wr_ptr] <= WriteData[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         leds     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         cycles   <= '0;
         bus_err  <= 1'b0;
      end else begin
         cycles <= cycles + 32'd1;
         if (MemWrite && led_hit)
            leds <= WriteData[7:0];
         if (MemWrite && unmapped)
            bus_err <= 1'b1;
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (MemWrite && status_hit && WriteData[2])
            overflow <= 1'b0;
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      ReadData = '0;
      if (ram_hit)
         ReadData = ram_mem[ram_idx];
      else if (led_hit)
         ReadData = {24'b0, leds};
      else if (status_hit)
         ReadData = {19'b0, count5, 5'b0, overflow, full, empty};
      else if (cycles_hit)
         ReadData = cycles;
   end

endmodule

// File: tb/tb_arm_data_bus.sv
// Directed bench for arm_data_bus: RAM, LED, FIFO fill/drain/overflow,
// unmapped writes, cycle counter and mid-operation reset.
module tb_arm_data_bus;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  leds;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_err;

   int vectors;
   int miscompares;

   logic [7:0] drain_exp [8];

   arm_data_bus #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .MemWrite(MemWrite),
      .DataAdr(DataAdr),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .leds(leds),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs settle 1 time unit before any check, well clear of the next edge.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
      MemWrite  = we;
      DataAdr   = adr;
      WriteData = data;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      tx_ready    = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // Reset state and cycle counter after release
      applyStimulus(1'b0, 32'h100C, 32'h0);
      checkOutput("cycles_at_release", ReadData, 32'd0);
      checkOutput("leds_reset", {24'b0, leds}, 32'h0);
      checkOutput("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
      checkOutput("bus_err_reset", {31'b0, bus_err}, 32'h0);
      repeat (5) tick();
      checkOutput("cycles_5th", ReadData, 32'd5);
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("status_reset", ReadData, 32'h1);

      // RAM store/load, and read-during-write returns old data
      applyStimulus(1'b1, 32'h64, 32'd7);
      tick();
      applyStimulus(1'b0, 32'h64, 32'h0);
      checkOutput("ram_64", ReadData, 32'd7);
      applyStimulus(1'b1, 32'h60, 32'h1111_1111);
      tick();
      applyStimulus(1'b1, 32'h60, 32'h2222_2222);
      checkOutput("ram_60_old", ReadData, 32'h1111_1111);
      tick();
      applyStimulus(1'b0, 32'h60, 32'h0);
      checkOutput("ram_60_new", ReadData, 32'h2222_2222);

      // LED register
      applyStimulus(1'b1, 32'h1000, 32'h1A5);
      tick();
      applyStimulus(1'b0, 32'h1000, 32'h0);
      checkOutput("leds_write", {24'b0, leds}, 32'hA5);
      checkOutput("leds_read", ReadData, 32'hA5);

      // FIFO fill past full with sink stalled
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b1, 32'h1004, 32'(i));
         tick();
      end
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("status_full_ovf", ReadData, 32'h806);
      checkOutput("head_byte", {24'b0, tx_data}, 32'h1);
      applyStimulus(1'b0, 32'h1004, 32'h0);
      checkOutput("tx_read_zero", ReadData, 32'h0);
      applyStimulus(1'b1, 32'h1008, 32'h4);
      tick();
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("status_ovf_cleared", ReadData, 32'h802);

      // Drain: bytes 1..8 in order, byte 9 was dropped
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         #1;
         checkOutput("drain_valid", {31'b0, tx_valid}, 32'h1);
         checkOutput("drain_byte", {24'b0, tx_data}, 32'(i));
         tick();
      end
      tx_ready = 1'b0;
      #1;
      checkOutput("drained_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("status_empty", ReadData, 32'h1);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'h1004, 32'h10 + 32'(i));
         tick();
      end
      tx_ready = 1'b1;
      applyStimulus(1'b1, 32'h1004, 32'h55);
      tick();
      tx_ready = 1'b0;
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("status_full_pushpop", ReadData, 32'h802);
      drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checkOutput("pushpop_byte", {24'b0, tx_data}, {24'b0, drain_exp[i]});
         tick();
      end
      tx_ready = 1'b0;
      #1;
      checkOutput("pushpop_empty", {31'b0, tx_valid}, 32'h0);

      // CYCLES write is harmless; unmapped write is sticky
      applyStimulus(1'b1, 32'h100C, 32'hFFFF_FFFF);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("cycles_write_no_err", {31'b0, bus_err}, 32'h0);
      applyStimulus(1'b1, 32'h2000, 32'h1234);
      tick();
      applyStimulus(1'b0, 32'h2000, 32'h0);
      checkOutput("bus_err_set", {31'b0, bus_err}, 32'h1);
      checkOutput("unmapped_read", ReadData, 32'h0);
      repeat (3) tick();
      checkOutput("bus_err_sticky", {31'b0, bus_err}, 32'h1);

      // Mid-operation reset with bytes queued; a RAM store during reset commits
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h1004, 32'hA0 + 32'(i));
         tick();
      end
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("status_three", ReadData, 32'h300);
      reset = 1'b1;
      applyStimulus(1'b1, 32'h68, 32'h0000_CAFE);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 32'h1008, 32'h0);
      checkOutput("tx_valid_after_reset", {31'b0, tx_valid}, 32'h0);
      checkOutput("status_after_reset", ReadData, 32'h1);
      checkOutput("bus_err_after_reset", {31'b0, bus_err}, 32'h0);
      checkOutput("leds_after_reset", {24'b0, leds}, 32'h0);
      applyStimulus(1'b0, 32'h64, 32'h0);
      checkOutput("ram_kept", ReadData, 32'd7);
      applyStimulus(1'b0, 32'h68, 32'h0);
      checkOutput("ram_write_in_reset", ReadData, 32'h0000_CAFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
